// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - tagged command FIFO and single-issue sequencer for the registered ALU
// Optional: define ALU_CMD_FILTER_EN to answer 32-bit MUL (op 6, size 1) locally instead of issuing it.
module alu_cmd_sequencer #(
  parameter int DEPTH      = 4,
  parameter int TAG_W      = 4,
  parameter int RESULT_LAT = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic             cmd_size,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic             alu_valid,
  output logic [2:0]       alu_command,
  output logic             alu_size,
  output logic [31:0]      alu_in_a,
  output logic [31:0]      alu_in_b,
  input  logic [31:0]      alu_result,
  input  logic [1:0]       alu_signal,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic [1:0]       rsp_signal,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [15:0]      issue_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = (RESULT_LAT > 1) ? $clog2(RESULT_LAT) : 1;
  localparam int EW = 3 + 1 + 32 + 32 + TAG_W;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state;
  state_t           state_next;
  logic [EW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic             ready_q;
  logic [LW-1:0]    lat_cnt;
  logic [TAG_W-1:0] tag_q;

  logic [2:0]       head_op;
  logic             head_size;
  logic [31:0]      head_a;
  logic [31:0]      head_b;
  logic [TAG_W-1:0] head_tag;

  logic push;
  logic pop;
  logic empty;
  logic head_filtered;
  logic load_issue;
  logic load_filtered;
  logic capture;

  assign {head_op, head_size, head_a, head_b, head_tag} = mem[rd_ptr];
  assign empty     = (count == '0);
  assign cmd_ready = ready_q;
  assign push      = cmd_valid && ready_q;

`ifdef ALU_CMD_FILTER_EN
  assign head_filtered = (head_op == 3'd6) && head_size;
`else
  assign head_filtered = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_op, cmd_size, cmd_a, cmd_b, cmd_tag};
    end
  end

  always_comb begin
    state_next    = state;
    pop           = 1'b0;
    load_issue    = 1'b0;
    load_filtered = 1'b0;
    capture       = 1'b0;
    case (state)
      IDLE:  state_next = IDLE;
      ISSUE: state_next = WAIT;
      WAIT: begin
        if (lat_cnt == LW'(RESULT_LAT - 1)) begin
          capture    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // IDLE and an accepted RESP both hand the next head straight to the issue path
    if ((state == IDLE || (state == RESP && rsp_ready)) && !empty) begin
      pop = 1'b1;
      if (head_filtered) begin
        load_filtered = 1'b1;
        state_next    = RESP;
      end else begin
        load_issue = 1'b1;
        state_next = ISSUE;
      end
    end
  end

  assign count_next = count + CW'(push) - CW'(pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      ready_q     <= 1'b0;
      lat_cnt     <= '0;
      tag_q       <= '0;
      alu_valid   <= 1'b0;
      alu_command <= '0;
      alu_size    <= 1'b0;
      alu_in_a    <= '0;
      alu_in_b    <= '0;
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_signal  <= '0;
      rsp_tag     <= '0;
      issue_count <= '0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      ready_q   <= (count_next != CW'(DEPTH));
      alu_valid <= (state_next == ISSUE);
      rsp_valid <= (state_next == RESP);
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (load_issue) begin
        alu_command <= head_op;
        alu_size    <= head_size;
        alu_in_a    <= head_a;
        alu_in_b    <= head_b;
        tag_q       <= head_tag;
      end
      if (state == ISSUE) begin
        issue_count <= issue_count + 16'd1;
        lat_cnt     <= '0;
      end else if (state == WAIT) begin
        lat_cnt <= lat_cnt + LW'(1);
      end
      if (capture) begin
        rsp_result <= alu_result;
        rsp_signal <= alu_signal;
        rsp_tag    <= tag_q;
      end
      if (load_filtered) begin
        rsp_result <= '0;
        rsp_signal <= 2'b11;
        rsp_tag    <= head_tag;
      end
    end
  end

endmodule
